// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the unified-memory port arbiter: FSM encodings,
// latency counter width and default word size.
package mem_port_arbiter_pkg;

  localparam int WORD_SIZE_DEF = 16;
  localparam int LAT_CNT_W     = 4;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_I_ACC = 2'd1,
    ARB_D_ACC = 2'd2
  } arb_state_e;

  // Value loaded into the down-counter at grant; zero means "final access cycle".
  function automatic logic [LAT_CNT_W-1:0] lat_load(input int lat);
    return LAT_CNT_W'(lat - 1);
  endfunction

endpackage

// File: rtl/access_counter.sv
// Resettable wrapping event counter with an increment enable.
module access_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         inc_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q;

  // Count completed accesses; wraps naturally at 2^W.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= {W{1'b0}};
    end else if (inc_i) begin
      count_q <= count_q + {{(W-1){1'b0}}, 1'b1};
    end else begin
      count_q <= count_q;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-ported fixed-latency memory arbiter between instruction fetch and
// MEM-stage data access; data has priority, the just-served port is excluded.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int WORD_SIZE = WORD_SIZE_DEF,
  parameter int LATENCY   = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 i_req,
  input  logic [WORD_SIZE-1:0] i_addr,
  output logic [WORD_SIZE-1:0] i_data,
  output logic                 i_ready,
  input  logic                 d_read,
  input  logic                 d_write,
  input  logic [WORD_SIZE-1:0] d_addr,
  input  logic [WORD_SIZE-1:0] d_wdata,
  output logic [WORD_SIZE-1:0] d_rdata,
  output logic                 d_ready,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic [WORD_SIZE-1:0] mem_addr,
  output logic [WORD_SIZE-1:0] mem_wdata,
  input  logic [WORD_SIZE-1:0] mem_rdata,
  output logic                 stall_if,
  output logic                 stall_mem,
  output logic [WORD_SIZE-1:0] i_count,
  output logic [WORD_SIZE-1:0] d_count,
  output logic                 err_rw
);

  localparam logic [LAT_CNT_W-1:0] LAT_LOAD = lat_load(LATENCY);
  localparam logic [WORD_SIZE-1:0] ZERO_W   = {WORD_SIZE{1'b0}};

  arb_state_e           state_q;
  logic [LAT_CNT_W-1:0] cnt_q;
  logic [WORD_SIZE-1:0] addr_q;
  logic [WORD_SIZE-1:0] wdata_q;
  logic                 is_write_q;
  logic                 err_q;

  logic busy_s, done_s, d_req_s, grant_d_s, grant_i_s, i_ready_s, d_ready_s;

  assign d_req_s   = d_read | d_write;
  assign busy_s    = (state_q != ARB_IDLE);
  assign done_s    = busy_s && (cnt_q == {LAT_CNT_W{1'b0}});
  assign i_ready_s = (state_q == ARB_I_ACC) && (cnt_q == {LAT_CNT_W{1'b0}});
  assign d_ready_s = (state_q == ARB_D_ACC) && (cnt_q == {LAT_CNT_W{1'b0}});

  // Grant decision: data first, but the port finishing at this edge sits out once.
  always_comb begin
    grant_d_s = 1'b0;
    grant_i_s = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        grant_d_s = d_req_s;
        grant_i_s = !d_req_s && i_req;
      end
      ARB_I_ACC: begin
        if (done_s) grant_d_s = d_req_s;
        else        grant_d_s = 1'b0;
      end
      ARB_D_ACC: begin
        if (done_s) grant_i_s = i_req;
        else        grant_i_s = 1'b0;
      end
      default: begin
        grant_d_s = 1'b0;
        grant_i_s = 1'b0;
      end
    endcase
  end

  // FSM, access latches and latency down-counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ARB_IDLE;
      cnt_q      <= {LAT_CNT_W{1'b0}};
      addr_q     <= ZERO_W;
      wdata_q    <= ZERO_W;
      is_write_q <= 1'b0;
      err_q      <= 1'b0;
    end else if (grant_d_s) begin
      state_q    <= ARB_D_ACC;
      cnt_q      <= LAT_LOAD;
      addr_q     <= d_addr;
      wdata_q    <= d_wdata;
      is_write_q <= d_write;
      err_q      <= err_q | (d_read & d_write);
    end else if (grant_i_s) begin
      state_q    <= ARB_I_ACC;
      cnt_q      <= LAT_LOAD;
      addr_q     <= i_addr;
      wdata_q    <= ZERO_W;
      is_write_q <= 1'b0;
    end else if (done_s) begin
      state_q <= ARB_IDLE;
    end else if (busy_s) begin
      cnt_q <= cnt_q - {{(LAT_CNT_W-1){1'b0}}, 1'b1};
    end else begin
      state_q <= state_q;
    end
  end

  assign i_ready   = i_ready_s;
  assign d_ready   = d_ready_s;
  assign i_data    = i_ready_s ? mem_rdata : ZERO_W;
  assign d_rdata   = (d_ready_s && !is_write_q) ? mem_rdata : ZERO_W;
  assign mem_read  = (state_q == ARB_I_ACC) || ((state_q == ARB_D_ACC) && !is_write_q);
  assign mem_write = (state_q == ARB_D_ACC) && is_write_q;
  assign mem_addr  = busy_s ? addr_q : ZERO_W;
  assign mem_wdata = busy_s ? wdata_q : ZERO_W;
  // Stalls are forced low while in reset so every output reads 0.
  assign stall_if  = reset_n && i_req && !i_ready_s;
  assign stall_mem = reset_n && d_req_s && !d_ready_s;
  assign err_rw    = err_q;

  access_counter #(.W(WORD_SIZE)) u_i_count (
    .clk     (clk),
    .reset_n (reset_n),
    .inc_i   (i_ready_s),
    .count_o (i_count)
  );

  access_counter #(.W(WORD_SIZE)) u_d_count (
    .clk     (clk),
    .reset_n (reset_n),
    .inc_i   (d_ready_s),
    .count_o (d_count)
  );

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates a single-ported, fixed-latency unified memory between the pipeline's instruction-fetch port and its MEM-stage data port. It latches one access at a time, drives the memory command for the configured number of cycles, and returns data with a one-cycle ready pulse. It generates the IF and MEM stall signals that the data path uses to freeze its pipeline registers. It sits between `data_path` (readM1/address1/data1 and readM2/writeM2/address2/data2 sides) and the external memory model.

## Interface
Parameters:
- `WORD_SIZE`, 16, address/data width
- `LATENCY`, 2, memory cycles per access (legal 1..15)

Ports:
- `clk`  in  1  clock; all state updates on posedge
- `reset_n`  in  1  reset; asynchronous and active-low
- `i_req`  in  1  IF stage wants a fetch
- `i_addr`  in  WORD_SIZE  fetch address (PC)
- `i_data`  out  WORD_SIZE  fetched instruction; valid only while `i_ready`=1
- `i_ready`  out  1  fetch completes this cycle
- `d_read` / `d_write`  in  1  MEM stage load / store request
- `d_addr`, `d_wdata`  in  WORD_SIZE  data address, store data
- `d_rdata`  out  WORD_SIZE  load data; valid only while `d_ready`=1
- `d_ready`  out  1  data access completes this cycle
- `mem_read` / `mem_write`  out  1  memory command
- `mem_addr`, `mem_wdata`  out  WORD_SIZE  latched address, latched store data
- `mem_rdata`  in  WORD_SIZE  memory read data, valid in the final access cycle
- `stall_if`  out  1  `i_req` & !`i_ready`
- `stall_mem`  out  1  (`d_read`|`d_write`) & !`d_ready`
- `i_count`, `d_count`  out  WORD_SIZE  completed fetches / data accesses
- `err_rw`  out  1  sticky: `d_read` & `d_write` both sampled at a grant

## Operation
- FSM states: IDLE, I_ACC, D_ACC. Reset state is IDLE. On reset all outputs are 0: commands low, ready low, counters 0, `err_rw` 0, latched address/data 0.
- Grant (taken in IDLE, or at a completion edge): the data request has priority over fetch. The request from the port completing at that edge is excluded from the grant, which gives alternating service under contention and prevents IF starvation.
- On grant: latch the address, store data, and op type. Load the down-counter with LATENCY-1. Enter I_ACC or D_ACC.
- d_read & d_write both asserted at grant: treat as a write and set `err_rw`.
- In the ACC states:
  - Drive `mem_addr` and `mem_wdata` from the latches.
  - `mem_read` = 1 for a fetch or load; `mem_write` = 1 for a store.
  - Decrement the counter each cycle.
  - When the counter reaches 0: assert `i_ready` or `d_ready` combinationally. `i_data`/`d_rdata` = `mem_rdata` (store: `d_rdata` = 0). Increment the matching counter, which wraps at 2^WORD_SIZE.
  - At the completion edge, go to the next grant if any non-excluded request is pending, else go to IDLE.
- Requesters must hold address, data, and request stable until ready. The arbiter ignores input changes after grant.
- Requests arriving in IDLE are granted at the next edge. No combinational request-to-command path exists.

## Timing
- Latency: a request sampled at edge N (state IDLE) gets ready in cycle N+LATENCY.
- A back-to-back access from the other port starts with no bubble. The same port re-requesting after its own completion waits one IDLE cycle unless the other port is pending.
- LATENCY=1: one ACC cycle; ready is asserted in the first ACC cycle.
- Ready is a single-cycle pulse per access. Ready is never asserted in IDLE.
- Reset asserted mid-access: immediately go to IDLE, drop commands, discard the access, clear the counters.

## Structure
- Shared package (alongside `opcodes.v` defines):
  - FSM state encodings (`ARB_IDLE`, `ARB_I_ACC`, `ARB_D_ACC`)
  - latency counter width (4)
  - `WORD_SIZE` taken from the existing define
- One natural sub-module: `access_counter`, a resettable wrapping WORD_SIZE counter with an increment enable. Instantiate it twice, for `i_count` and `d_count`.
- All other logic (FSM, latches, output muxing) stays in one module.

## Test plan
- Reset, then a single fetch with i_addr=0x0010, LATENCY=2, mem_rdata=0x6A01:
  - i_ready is high exactly in cycle 2; i_data=0x6A01; i_count=1; stall_if is high in cycles 0–1.
- Simultaneous i_req and d_read (d_addr=0x0020), held:
  - D_ACC is granted first; d_ready in cycle 2.
  - I_ACC follows with no bubble; i_ready in cycle 4.
- Store: d_write, d_addr=0x0030, d_wdata=0xBEEF, with d_addr/d_wdata changed after grant:
  - mem_write=1 for 2 cycles; mem_addr=0x0030 and mem_wdata=0xBEEF stay stable throughout; d_count=1.
- Continuous i_req and d_read for 20 cycles:
  - Grants strictly alternate D/I.
  - Neither port waits more than 2·LATENCY cycles.
- d_read & d_write asserted together:
  - The access is performed as a write and err_rw=1 stays set.
  - Then assert reset_n=0 mid-access: all outputs are 0 asynchronously, and state is IDLE after release.
